tvr_pwm_dac_mc: RTL and testbench
=================================

// Module: tvr_pwm_dac_mc
// PURPOSE
//   Multi-channel audio DAC back end for the TVR receive chain; successor of the single-channel PWM test DAC.
//   Takes WIDTH-bit audio samples (from the audio handler) for CHANNELS channels through a valid/ready handshake.
//   Double-buffers each sample and updates duty only on period boundaries (glitch-free).
//   Per-period selectable mode: classic PWM or first-order delta-sigma (noise-shaped) bitstream.
// PARAMETERS
//   WIDTH     10  sample / counter width; PWM period = 2**WIDTH clk_in cycles
//   CHANNELS  2   number of independent output channels (shared counter and handshake)
//   SIGNED_IN 1   1: data_in is two's complement, MSB inverted to offset binary; 0: data_in is unsigned
// PORTS
//   clk_in        in   1                sole clock (PWM rate, e.g. 200 MHz PLL)
//   RST           in   1                synchronous reset, active-high
//   pwm_en        in   1                1: run; 0: outputs low, counter/accumulators held at 0
//   mode          in   1                0: PWM, 1: delta-sigma; sampled at period start only
//   sample_valid  in   1                data_in holds a new sample frame
//   sample_ready  out  1                frame accepted on cycle where valid & ready
//   data_in       in   CHANNELS*WIDTH   channel c at [c*WIDTH +: WIDTH]
//   PWM_OUT       out  CHANNELS         registered 1-bit DAC outputs
//   period_start  out  1                1-cycle pulse, first cycle of each period (cnt==0, pwm_en=1)
//   overrun       out  1                1-cycle pulse: sample_valid & ~sample_ready (frame dropped)
// BEHAVIOUR
//   Reset (RST=1 at clk edge): cnt=0, shadow=0, active=0, acc=0, pending=0, mode_q=0;
//     PWM_OUT=0, period_start=0, overrun=0; sample_ready=0 while RST high, 1 the cycle after.
//   Counter: cnt free-runs 0..2**WIDTH-1 and wraps when pwm_en=1; wrap = pwm_en & (cnt==2**WIDTH-1).
//   Conversion: u = SIGNED_IN ? {~d[WIDTH-1], d[WIDTH-2:0]} : d; applied when loading shadow.
//   Handshake: sample_ready = ~RST & (~pending | wrap | ~pwm_en) (combinational).
//     accept = sample_valid & sample_ready -> shadow <= u (all channels), pending <= 1.
//   Transfer shadow->active (all channels), pending cleared unless a new accept the same cycle:
//     - on wrap when pending=1; same cycle mode_q <= mode (mode_q also loads on wrap when pending=0);
//     - every cycle while pwm_en=0 (latest sample is active when enabled).
//     Simultaneous wrap+accept: old shadow goes to active, new frame goes to shadow, pending stays 1.
//   Valid while not ready: frame dropped, overrun=1 for that cycle, no state change; valid may stay high.
//   PWM mode (mode_q=0): PWM_OUT[c] <= (cnt < active[c]); 1-cycle latency from cnt.
//     active=0 -> constantly low; active=2**WIDTH-1 -> low 1 cycle per period.
//   Delta-sigma mode (mode_q=1): {carry,acc[c]} = acc[c] + active[c] (WIDTH+1 bit sum);
//     acc[c] <= sum[WIDTH-1:0]; PWM_OUT[c] <= carry. Ones-density over 2**WIDTH cycles = active/2**WIDTH exactly.
//   Mode change: acc cleared at the wrap where mode_q changes; never mid-period.
//   period_start <= pwm_en & wrap (registered, coincides with first output bit of the new period).
//   pwm_en falling: next edge PWM_OUT=0, cnt=0, acc=0, period_start=0; no partial-period output.
//   pwm_en rising: first period starts at cnt=0, period_start fires after first full period (at wrap).
//   RST mid-period: all state cleared next edge; pending sample lost.
// TESTING
//   1 PWM, SIGNED_IN=1, WIDTH=10, ch0=0, ch1=-512 -> PWM_OUT[0] high 512/1024 cycles, PWM_OUT[1] never high.
//   2 Load ch0=+100 mid-period -> duty changes only after next period_start; prior period keeps old duty (no glitch).
//   3 Two frames 10 cycles apart in one period -> 2nd: sample_ready=0, overrun pulse, 1st frame applied at wrap.
//   4 Valid held at wrap with pending=1 -> accepted that cycle, old shadow active, new pending; no overrun.
//   5 Delta-sigma, u=256 -> exactly 256 ones per 1024 cycles, never two consecutive ones; u=0 -> all zero.
//   6 RST/pwm_en=0 mid-period -> next edge all outputs 0, cnt=0; re-enable -> period_start after 1024 cycles.

Source files
------------

// File: rtl/tvr_pwm_dac_mc.sv
// Multi-channel audio DAC back end: per-channel PWM or first-order delta-sigma bitstream.
// Latency: PWM_OUT is registered one clk_in cycle after the counter value it encodes; a new frame reaches the output at the next period boundary.
// Backpressure: sample_ready drops while a frame is pending mid-period; a frame offered while not ready is dropped and flagged on overrun.
//
// Ports:
//   clk_in        sole clock, PWM rate
//   RST           synchronous reset, active-high
//   pwm_en        1: run; 0: outputs low, counter and accumulators held at zero
//   mode          0: PWM, 1: delta-sigma; takes effect only at a period boundary
//   sample_valid  data_in holds a new frame of CHANNELS samples
//   sample_ready  frame is accepted on a cycle where sample_valid & sample_ready
//   data_in       channel c at [c*WIDTH +: WIDTH]
//   PWM_OUT       registered 1-bit DAC outputs, one per channel
//   period_start  1-cycle pulse during the first counter cycle (cnt==0) of every period
//   overrun       1-cycle pulse when a frame is offered but cannot be accepted

module tvr_pwm_dac_mc #(
    parameter int WIDTH     = 10,
    parameter int CHANNELS  = 2,
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic                      clk_in,
    input  logic                      RST,
    input  logic                      pwm_en,
    input  logic                      mode,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [CHANNELS-1:0]       PWM_OUT,
    output logic                      period_start,
    output logic                      overrun
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    // Flipping the MSB turns two's complement into offset binary, so that
    // the most negative sample maps to duty 0 and zero maps to half scale.
    localparam logic [WIDTH-1:0] MSB_FLIP = SIGNED_IN ? (CNT_ONE << (WIDTH - 1)) : '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]                 cnt;
    logic [CHANNELS-1:0][WIDTH-1:0]   shadow;   // last accepted frame
    logic [CHANNELS-1:0][WIDTH-1:0]   active;   // frame being converted this period
    logic [CHANNELS-1:0][WIDTH-1:0]   acc;      // delta-sigma error accumulators
    logic                             pending;  // shadow holds a frame not yet made active
    logic                             mode_q;   // mode in force for the current period

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                             wrap;
    logic                             accept;
    logic                             xfer;
    logic                             mode_chg;
    logic [CHANNELS-1:0][WIDTH-1:0]   u_conv;
    logic [CHANNELS-1:0][WIDTH:0]     ds_sum;
    logic [CHANNELS-1:0]              pwm_bit;

    // Last cycle of a running period; every period-boundary action keys off this.
    assign wrap = pwm_en & (cnt == CNT_MAX);

    // A pending frame blocks new ones until it has been handed to the
    // converter. On the wrap cycle the pending frame moves to active while
    // the new one lands in shadow, so the input is open on that cycle too.
    // While disabled the shadow is copied to active every cycle, so the
    // input is always open.
    assign sample_ready = ~RST & (~pending | wrap | ~pwm_en);
    assign accept       = sample_valid & sample_ready;
    assign overrun      = ~RST & sample_valid & ~sample_ready;

    assign xfer     = (wrap & pending) | ~pwm_en;
    assign mode_chg = wrap & (mode != mode_q);

    always_comb begin
        u_conv  = '0;
        ds_sum  = '0;
        pwm_bit = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            u_conv[c]  = data_in[c*WIDTH +: WIDTH] ^ MSB_FLIP;
            // One extra bit: the carry out is the delta-sigma output bit.
            ds_sum[c]  = {1'b0, acc[c]} + {1'b0, active[c]};
            pwm_bit[c] = (cnt < active[c]);
        end
    end

    // ------------------------------------------------------------------
    // Period counter and period_start
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (RST) begin
            cnt          <= '0;
            period_start <= 1'b0;
        end else if (!pwm_en) begin
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt + CNT_ONE;
            period_start <= wrap;
        end
    end

    // ------------------------------------------------------------------
    // Double buffer: shadow -> active, pending flag, period mode
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (RST) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            if (accept) begin
                shadow <= u_conv;
            end

            // The old shadow value is what transfers; a frame accepted on
            // the same cycle stays pending for the following boundary.
            if (xfer) begin
                active <= shadow;
            end

            if (accept) begin
                pending <= 1'b1;
            end else if (xfer) begin
                pending <= 1'b0;
            end

            if (wrap) begin
                mode_q <= mode;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output modulators
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (RST || !pwm_en) begin
            PWM_OUT <= '0;
            acc     <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (mode_q) begin
                    PWM_OUT[c] <= ds_sum[c][WIDTH];
                    // A mode change restarts the accumulator so the new
                    // period's ones-density is exact from its first cycle.
                    acc[c]     <= mode_chg ? '0 : ds_sum[c][WIDTH-1:0];
                end else begin
                    PWM_OUT[c] <= pwm_bit[c];
                    acc[c]     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tvr_pwm_dac_mc.sv
module tb_tvr_pwm_dac_mc;

    localparam int W  = 10;
    localparam int CH = 2;

    logic              clk_in = 1'b0;
    logic              RST;
    logic              pwm_en;
    logic              mode;
    logic              sample_valid;
    logic              sample_ready;
    logic [CH*W-1:0]   data_in;
    logic [CH-1:0]     PWM_OUT;
    logic              period_start;
    logic              overrun;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    tvr_pwm_dac_mc #(
        .WIDTH     (W),
        .CHANNELS  (CH),
        .SIGNED_IN (1'b1)
    ) dut (
        .clk_in       (clk_in),
        .RST          (RST),
        .pwm_en       (pwm_en),
        .mode         (mode),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .data_in      (data_in),
        .PWM_OUT      (PWM_OUT),
        .period_start (period_start),
        .overrun      (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Returns 1 ns after the rising edge; inputs are driven and outputs sampled there.
    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [W-1:0] c0, input logic [W-1:0] c1);
        data_in      = {c1, c0};
        sample_valid = 1'b1;
    endtask

    task automatic count_n(input int n, output int o0, output int o1, output int consec0);
        logic prev;
        o0      = 0;
        o1      = 0;
        consec0 = 0;
        prev    = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick;
            o0 += int'(PWM_OUT[0]);
            o1 += int'(PWM_OUT[1]);
            if (PWM_OUT[0] && prev) consec0++;
            prev = PWM_OUT[0];
        end
    endtask

    // Ticks until period_start is seen (inclusive), bounded by max.
    task automatic count_until_ps(input int max, output int n, output int o0, output int o1);
        n  = 0;
        o0 = 0;
        o1 = 0;
        for (int i = 0; i < max; i++) begin
            tick;
            n++;
            o0 += int'(PWM_OUT[0]);
            o1 += int'(PWM_OUT[1]);
            if (period_start) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, o0, o1, cs;
        int waits, bad_ov;
        logic found;

        RST          = 1'b1;
        pwm_en       = 1'b0;
        mode         = 1'b0;
        sample_valid = 1'b0;
        data_in      = '0;
        repeat (3) tick;

        // Reset state
        check("rst_ready", 32'(sample_ready), 0);
        check("rst_pwm_out", 32'(PWM_OUT), 0);
        check("rst_period_start", 32'(period_start), 0);
        check("rst_overrun", 32'(overrun), 0);
        RST = 1'b0;
        #1;
        check("ready_after_rst", 32'(sample_ready), 1);

        // 1: PWM, ch0=0 -> 512, ch1=-512 -> 0; load while disabled
        send(10'h000, 10'h200);
        #1;
        check("t1_ready", 32'(sample_ready), 1);
        tick;
        sample_valid = 1'b0;
        tick;
        pwm_en = 1'b1;
        count_until_ps(2100, n, o0, o1);
        check("t1_first_ps_latency", 32'(n), 1024);
        check("t1_ch0_ones", 32'(o0), 512);
        check("t1_ch1_ones", 32'(o1), 0);

        // 2: ch0=+100 (612) loaded at cnt=300; old duty kept until boundary
        repeat (300) tick;
        send(10'd100, 10'h200);
        #1;
        check("t2_ready", 32'(sample_ready), 1);
        tick;
        sample_valid = 1'b0;
        count_until_ps(2100, n, o0, o1);
        check("t2_ticks_to_ps", 32'(n), 723);
        check("t2_old_duty_ch0", 32'(o0), 211);
        check("t2_old_duty_ch1", 32'(o1), 0);
        count_n(1024, o0, o1, cs);
        check("t2_new_duty_ch0", 32'(o0), 612);
        check("t2_new_duty_ch1", 32'(o1), 0);

        // 3: two frames 10 cycles apart; second dropped
        repeat (100) tick;
        send(10'd200, 10'h3FF);
        #1;
        check("t3_a_ready", 32'(sample_ready), 1);
        check("t3_a_overrun", 32'(overrun), 0);
        tick;
        sample_valid = 1'b0;
        repeat (9) tick;
        send(10'h200, 10'h000);
        #1;
        check("t3_b_ready", 32'(sample_ready), 0);
        check("t3_b_overrun", 32'(overrun), 1);
        tick;
        sample_valid = 1'b0;
        #1;
        check("t3_overrun_clear", 32'(overrun), 0);
        count_until_ps(2100, n, o0, o1);
        check("t3_ticks_to_ps", 32'(n), 913);
        count_n(1024, o0, o1, cs);
        check("t3_ch0_frame_a", 32'(o0), 712);
        check("t3_ch1_frame_a", 32'(o1), 511);

        // 4: valid held until the wrap cycle while a frame is pending
        repeat (50) tick;
        send(10'h000, 10'h000);
        #1;
        check("t4_c_ready", 32'(sample_ready), 1);
        tick;
        send(10'h300, 10'h100);
        waits  = 0;
        bad_ov = 0;
        found  = 1'b0;
        for (int i = 0; i < 2100; i++) begin
            #1;
            if (sample_ready) begin
                found = 1'b1;
                break;
            end
            if (!overrun) bad_ov++;
            waits++;
            tick;
        end
        check("t4_accepted", 32'(found), 1);
        check("t4_wait_cycles", 32'(waits), 972);
        check("t4_overrun_while_blocked", 32'(bad_ov), 0);
        check("t4_no_overrun_at_accept", 32'(overrun), 0);
        tick;
        sample_valid = 1'b0;
        check("t4_accept_at_wrap", 32'(period_start), 1);
        count_n(1024, o0, o1, cs);
        check("t4_ch0_frame_c", 32'(o0), 512);
        check("t4_ch1_frame_c", 32'(o1), 512);
        count_n(1024, o0, o1, cs);
        check("t4_ch0_frame_d", 32'(o0), 256);
        check("t4_ch1_frame_d", 32'(o1), 768);

        // 5: delta-sigma, ch0 u=256, ch1 u=0; mode set mid-period
        mode = 1'b1;
        send(10'h300, 10'h200);
        #1;
        check("t5_ready", 32'(sample_ready), 1);
        tick;
        sample_valid = 1'b0;
        count_until_ps(2100, n, o0, o1);
        check("t5_ticks_to_ps", 32'(n), 1023);
        check("t5_still_pwm_ch0", 32'(o0), 255);
        check("t5_still_pwm_ch1", 32'(o1), 767);
        count_n(1024, o0, o1, cs);
        check("t5_ds_ch0_ones", 32'(o0), 256);
        check("t5_ds_ch0_consecutive", 32'(cs), 0);
        check("t5_ds_ch1_ones", 32'(o1), 0);

        // 6a: pwm_en dropped mid-period, then re-enabled
        repeat (500) tick;
        pwm_en = 1'b0;
        tick;
        check("t6_dis_pwm_out", 32'(PWM_OUT), 0);
        check("t6_dis_period_start", 32'(period_start), 0);
        repeat (5) tick;
        check("t6_dis_pwm_out_held", 32'(PWM_OUT), 0);
        pwm_en = 1'b1;
        count_until_ps(2100, n, o0, o1);
        check("t6_reen_ps_latency", 32'(n), 1024);
        check("t6_reen_ds_ch0", 32'(o0), 256);

        // 6b: RST mid-period with a frame pending
        repeat (200) tick;
        mode = 1'b0;
        send(10'h1FF, 10'h1FF);
        #1;
        check("t6_f_ready", 32'(sample_ready), 1);
        tick;
        sample_valid = 1'b0;
        RST = 1'b1;
        #1;
        check("t6_rst_ready_low", 32'(sample_ready), 0);
        tick;
        check("t6_rst_pwm_out", 32'(PWM_OUT), 0);
        check("t6_rst_period_start", 32'(period_start), 0);
        RST = 1'b0;
        #1;
        check("t6_ready_after_rst", 32'(sample_ready), 1);
        count_until_ps(2100, n, o0, o1);
        check("t6_rst_ps_latency", 32'(n), 1024);
        check("t6_rst_ch0_zero", 32'(o0), 0);
        count_n(1024, o0, o1, cs);
        check("t6_pending_lost_ch0", 32'(o0), 0);
        check("t6_pending_lost_ch1", 32'(o1), 0);

        // Full-scale PWM: low one cycle per period
        send(10'h1FF, 10'h1FF);
        #1;
        check("t7_ready", 32'(sample_ready), 1);
        tick;
        sample_valid = 1'b0;
        count_until_ps(2100, n, o0, o1);
        count_n(1024, o0, o1, cs);
        check("t7_full_ch0", 32'(o0), 1023);
        check("t7_full_ch1", 32'(o1), 1023);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
